// File: rtl/piso_shift_tx_pkg.sv
// Shared definitions for the parallel-in/serial-out transmitter:
// state encodings, default word length and the counter-width helper.
package piso_shift_tx_pkg;

  // Two-state controller: waiting for a word, or streaming one out.
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  // Default word length; the matching SIPO receiver uses the same value.
  localparam int DEFAULT_WIDTH = 4;

  // Bit-counter width; guarded so a degenerate width still yields one bit.
  function automatic int cnt_w(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/piso_shift_tx.sv
// Parallel-in/serial-out transmitter. Accepts a WIDTH-bit word on a
// LOAD/READY handshake and drives it one bit per enabled clock edge on Q,
// with Q_VALID/LAST framing and back-to-back reload without an idle gap.
//
// Handshake: a word is accepted at a rising CLK edge where LOAD && READY.
// READY is combinational and true in IDLE, or in SHIFT on the final bit
// when EN is high (the word completes on that same edge). LOAD while READY
// is low is dropped; DIN is only sampled on the accept edge.
//
// BUSY is the state flop itself (1 = SHIFT) and doubles as the FSM view.
module piso_shift_tx
  import piso_shift_tx_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] DIN,
  input  logic             LOAD,
  output logic             READY,
  input  logic             EN,
  output logic             Q,
  output logic             Q_VALID,
  output logic             LAST,
  output logic             BUSY
);

  localparam int CNT_W = cnt_w(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic             q_q,     q_d;

  logic             at_last;
  logic             ready_int;

  // Head of the shift register: the bit that goes on the wire next.
  function automatic logic head_bit(input logic [WIDTH-1:0] v);
    return MSB_FIRST ? v[WIDTH-1] : v[0];
  endfunction

  // Move the register one place toward the head, zero-filling the tail.
  function automatic logic [WIDTH-1:0] shift_once(input logic [WIDTH-1:0] v);
    return MSB_FIRST ? (v << 1) : (v >> 1);
  endfunction

  // State register: every flop of the block, reset has top priority.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      q_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
    end
  end

  assign at_last   = (state_q == ST_SHIFT) && (cnt_q == CNT_LAST);
  assign ready_int = (state_q == ST_IDLE) || (at_last && EN);

  // Next-state and datapath: accept, shift, complete or reload.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (LOAD) begin
          state_d = ST_SHIFT;
          shreg_d = DIN;
          cnt_d   = '0;
        end
      end
      ST_SHIFT: begin
        if (EN) begin
          if (cnt_q == CNT_LAST) begin
            if (LOAD) begin
              // Reload on the final edge: next word starts with no bubble.
              shreg_d = DIN;
              cnt_d   = '0;
            end else begin
              state_d = ST_IDLE;
              shreg_d = '0;
              cnt_d   = '0;
            end
          end else begin
            shreg_d = shift_once(shreg_q);
            cnt_d   = cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    // Q is registered: it presents the head of the register being loaded.
    q_d = (state_d == ST_SHIFT) ? head_bit(shreg_d) : 1'b0;
  end

  // Output decode from the registered state.
  assign READY   = ready_int;
  assign LAST    = at_last;
  assign BUSY    = (state_q == ST_SHIFT);
  assign Q_VALID = (state_q == ST_SHIFT);
  assign Q       = q_q;

endmodule

// File: tb/tb_piso_shift_tx.sv
// Directed bench for piso_shift_tx (WIDTH=4): an MSB-first and an LSB-first
// instance share inputs; a vector table covers reset, single words,
// back-to-back reload, stall, drop and abort; a loopback sequence feeds Q
// into a small SIPO model.
module tb_piso_shift_tx;

  logic       clk = 1'b0;
  logic       rst, load, en;
  logic [3:0] din;
  logic       ready, q, qv, last, busy;
  logic       ready_l, q_l, qv_l, last_l, busy_l;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic       rst;
    logic       load;
    logic       en;
    logic [3:0] din;
    logic       ready;  // READY during the cycle, before the edge
    logic       q;      // MSB-first Q after the edge
    logic       ql;     // LSB-first Q after the edge
    logic       qv;
    logic       last;
    logic       busy;
  } vec_t;

  vec_t vq[$];

  // Receiver model for loopback: shift Q in on enabled edges with a valid bit.
  logic       lb_on   = 1'b0;
  logic [3:0] rx_bits = 4'b0000;
  int         rx_cnt  = 0;

  // Clock: 40 ns period.
  always #20 clk = ~clk;

  piso_shift_tx #(.WIDTH(4), .MSB_FIRST(1'b1)) u_dut (
    .CLK(clk), .RST(rst), .DIN(din), .LOAD(load), .READY(ready), .EN(en),
    .Q(q), .Q_VALID(qv), .LAST(last), .BUSY(busy)
  );

  piso_shift_tx #(.WIDTH(4), .MSB_FIRST(1'b0)) u_lsb (
    .CLK(clk), .RST(rst), .DIN(din), .LOAD(load), .READY(ready_l), .EN(en),
    .Q(q_l), .Q_VALID(qv_l), .LAST(last_l), .BUSY(busy_l)
  );

  always @(posedge clk) begin
    if (lb_on && qv && en) begin
      rx_bits <= {rx_bits[2:0], q};
      rx_cnt  <= rx_cnt + 1;
    end
  end

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic l, input logic e, input logic [3:0] d,
                     input logic rdy, input logic eq, input logic eql, input logic eqv,
                     input logic el, input logic eb);
    vec_t v;
    v.rst = r; v.load = l; v.en = e; v.din = d;
    v.ready = rdy; v.q = eq; v.ql = eql; v.qv = eqv; v.last = el; v.busy = eb;
    vq.push_back(v);
  endtask

  initial begin
    bit done;

    //     rst load en din      rdy q  ql qv last busy
    // Reset held with LOAD high: nothing accepted.
    add(1, 1, 1, 4'b1011,  1, 0, 0, 0, 0, 0);
    add(0, 0, 1, 4'b1011,  1, 0, 0, 0, 0, 0);
    // Single word 1011: MSB 1,0,1,1 / LSB 1,1,0,1; DIN changes after accept.
    add(0, 1, 1, 4'b1011,  1, 1, 1, 1, 0, 1);
    add(0, 0, 1, 4'b0000,  0, 0, 1, 1, 0, 1);
    add(0, 0, 1, 4'b0000,  0, 1, 0, 1, 0, 1);
    add(0, 0, 1, 4'b0000,  0, 1, 1, 1, 1, 1);
    add(0, 0, 1, 4'b0000,  1, 0, 0, 0, 0, 0);
    add(0, 0, 1, 4'b0000,  1, 0, 0, 0, 0, 0);
    // Back-to-back 1100 then 0011 with LOAD on the LAST cycle.
    add(0, 1, 1, 4'b1100,  1, 1, 0, 1, 0, 1);
    add(0, 0, 1, 4'b0000,  0, 1, 0, 1, 0, 1);
    add(0, 0, 1, 4'b0000,  0, 0, 1, 1, 0, 1);
    add(0, 0, 1, 4'b0000,  0, 0, 1, 1, 1, 1);
    add(0, 1, 1, 4'b0011,  1, 0, 1, 1, 0, 1);
    add(0, 0, 1, 4'b0000,  0, 0, 1, 1, 0, 1);
    add(0, 0, 1, 4'b0000,  0, 1, 0, 1, 0, 1);
    add(0, 0, 1, 4'b0000,  0, 1, 0, 1, 1, 1);
    add(0, 0, 1, 4'b0000,  1, 0, 0, 0, 0, 0);
    // Stall: 1001, EN low for 3 cycles after bit 1 (one LOAD dropped).
    add(0, 1, 1, 4'b1001,  1, 1, 1, 1, 0, 1);
    add(0, 0, 0, 4'b0000,  0, 1, 1, 1, 0, 1);
    add(0, 1, 0, 4'b0110,  0, 1, 1, 1, 0, 1);
    add(0, 0, 0, 4'b0000,  0, 1, 1, 1, 0, 1);
    add(0, 0, 1, 4'b0000,  0, 0, 0, 1, 0, 1);
    add(0, 0, 1, 4'b0000,  0, 0, 0, 1, 0, 1);
    add(0, 0, 1, 4'b0000,  0, 1, 1, 1, 1, 1);
    add(0, 0, 1, 4'b0000,  1, 0, 0, 0, 0, 0);
    // Drop while shifting, then abort with RST at cnt=2.
    add(0, 1, 1, 4'b1011,  1, 1, 1, 1, 0, 1);
    add(0, 1, 1, 4'b0110,  0, 0, 1, 1, 0, 1);
    add(0, 1, 1, 4'b0110,  0, 1, 0, 1, 0, 1);
    add(1, 1, 1, 4'b0110,  0, 0, 0, 0, 0, 0);
    add(0, 0, 1, 4'b0000,  1, 0, 0, 0, 0, 0);
    // Accept in IDLE with EN low, then a stall before streaming.
    add(0, 1, 0, 4'b1011,  1, 1, 1, 1, 0, 1);
    add(0, 0, 0, 4'b0000,  0, 1, 1, 1, 0, 1);
    add(0, 0, 1, 4'b0000,  0, 0, 1, 1, 0, 1);
    add(0, 0, 1, 4'b0000,  0, 1, 0, 1, 0, 1);
    add(0, 0, 1, 4'b0000,  0, 1, 1, 1, 1, 1);
    add(0, 0, 1, 4'b0000,  1, 0, 0, 0, 0, 0);

    // First reset edge brings both instances out of the unknown power-up state.
    rst = 1'b1; load = 1'b1; en = 1'b1; din = 4'b1011;
    @(posedge clk); #1;

    for (int i = 0; i < vq.size(); i++) begin
      rst  = vq[i].rst;
      load = vq[i].load;
      en   = vq[i].en;
      din  = vq[i].din;
      #1;
      check($sformatf("v%0d ready", i), {3'b0, ready}, {3'b0, vq[i].ready});
      @(posedge clk); #1;
      check($sformatf("v%0d q", i),     {3'b0, q},     {3'b0, vq[i].q});
      check($sformatf("v%0d q_lsb", i), {3'b0, q_l},   {3'b0, vq[i].ql});
      check($sformatf("v%0d q_valid", i), {3'b0, qv},  {3'b0, vq[i].qv});
      check($sformatf("v%0d last", i),  {3'b0, last},  {3'b0, vq[i].last});
      check($sformatf("v%0d busy", i),  {3'b0, busy},  {3'b0, busy_l & vq[i].busy} | {3'b0, vq[i].busy & ~busy_l});
      check($sformatf("v%0d busy_lsb", i), {3'b0, busy_l}, {3'b0, vq[i].busy});
    end

    // Loopback: 1011 MSB first into the receiver model.
    rst = 1'b0; en = 1'b1; load = 1'b1; din = 4'b1011; lb_on = 1'b1;
    @(posedge clk); #1;
    load = 1'b0; din = 4'b0000;
    done = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (!busy) begin
        done = 1'b1;
        break;
      end
    end
    lb_on = 1'b0;
    check("loopback finished", {3'b0, done}, 4'b0001);
    check("loopback bits", rx_bits, 4'b1011);
    check("loopback edges", rx_cnt[3:0], 4'd4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
